// File: rtl/or1k_pkg.sv
// Shared definitions for the OR1K instruction fetch slice.
// Holds the fetch FSM encoding, reset PC default, l.nop encoding and instruction width.
// No logic beyond a PC increment helper.
package or1k_pkg;

  localparam int unsigned         INST_W           = 32;
  localparam logic [31:0]         RESET_PC_DEFAULT = 32'h0000_0100;
  localparam logic [INST_W-1:0]   INST_NOP         = 32'h1500_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding
    S_HOLD  = 2'd1,  // instruction presented, decode stalled
    S_DROP  = 2'd2,  // waiting to discard a stale response
    S_ERR   = 2'd3   // halted on a misaligned redirect
  } fetch_state_e;

  // Sequential word address; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a response fetched while decode is stalled.
// Latency: written on the push edge, visible on vld_o/inst_o the next cycle.
// Backpressure: none of its own; the fetch FSM never pushes while it is full.
// Ports: clk_i/rst_ni (sync active-low), push_i + inst_i/pc_i/err_i write,
//        pop_i empties after use, flush_i empties on redirect, vld_o/inst_o/pc_o/err_o read.
module fetch_skid_buf
  import or1k_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [31:0]       pc_i,
  input  logic              err_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              vld_o,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o,
  output logic              err_o
);

  logic              vld_q;
  logic [INST_W-1:0] inst_q;
  logic [31:0]       pc_q;
  logic              err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (push_i) begin
      vld_q  <= 1'b1;
      inst_q <= inst_i;
      pc_q   <= pc_i;
      err_q  <= err_i;
    end else if (pop_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign inst_o = inst_q;
  assign pc_o   = pc_q;
  assign err_o  = err_q;

endmodule

// File: rtl/fetch_32i.sv
// OR1K instruction fetch: drives the instruction bus and presents one word at a time to decode.
// Latency: instruction valid one cycle after its ack; one instruction per cycle with single-cycle acks.
// Backpressure: stall_in holds the presented word and pauses requests (one extra request into a
//   skid buffer when FETCH_SKID_EN is defined).
// Ports: clk_in/reset_in (sync active-low); imem_* request/response bus; stall_in, branch_taken_in/
//   branch_target_in from the pipeline; inst_out/pc_out/inst_valid_out and error flags to decode.
module fetch_32i
  import or1k_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_in,
  input  logic              reset_in,
  output logic              imem_req_out,
  output logic [31:0]       imem_addr_out,
  input  logic              imem_ack_in,
  input  logic              imem_err_in,
  input  logic [INST_W-1:0] imem_data_in,
  input  logic              stall_in,
  input  logic              branch_taken_in,
  input  logic [31:0]       branch_target_in,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       pc_out,
  output logic              inst_valid_out,
  output logic              flag_ibus_err_out,
  output logic              flag_align_err_out
);

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;             // next fetch address
  logic [31:0]       drop_addr_q, drop_addr_d; // address of the response being discarded
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       iaddr_q, iaddr_d;
  logic              valid_q, valid_d;
  logic              ibus_err_q, ibus_err_d;
  logic              align_err_q, align_err_d;
  logic              run_q;                  // previous cycle was out of reset

  logic              req_raw, ack, out_busy, consume;
  logic [31:0]       addr_raw;
  logic [INST_W-1:0] resp_inst;

  logic              buf_vld, buf_err;
  logic [INST_W-1:0] buf_inst;
  logic [31:0]       buf_pc;

`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
  logic buf_push, buf_pop, buf_flush;

  fetch_skid_buf u_skid (
    .clk_i   (clk_in),
    .rst_ni  (reset_in),
    .push_i  (buf_push),
    .inst_i  (resp_inst),
    .pc_i    (pc_q),
    .err_i   (imem_err_in),
    .pop_i   (buf_pop),
    .flush_i (buf_flush),
    .vld_o   (buf_vld),
    .inst_o  (buf_inst),
    .pc_o    (buf_pc),
    .err_o   (buf_err)
  );
`else
  localparam bit SKID = 1'b0;
  assign buf_vld  = 1'b0;
  assign buf_err  = 1'b0;
  assign buf_inst = '0;
  assign buf_pc   = '0;
`endif

  assign out_busy  = valid_q && stall_in;
  assign consume   = valid_q && !stall_in;
  assign resp_inst = imem_err_in ? INST_NOP : imem_data_in;
  assign addr_raw  = (state_q == S_DROP) ? drop_addr_q : pc_q;

  // A new request may only start when the output slot can take its response
  // (or, with the skid buffer, while the buffer is still empty).
  always_comb begin
    req_raw = 1'b0;
    case (state_q)
      S_FETCH: req_raw = SKID || !out_busy;
      S_HOLD:  req_raw = SKID && !buf_vld;
      S_DROP:  req_raw = 1'b1;
      default: req_raw = 1'b0;
    endcase
  end

  assign imem_req_out  = reset_in && req_raw;
  assign imem_addr_out = addr_raw;
  assign ack           = imem_req_out && imem_ack_in;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    inst_d      = inst_q;
    iaddr_d     = iaddr_q;
    valid_d     = valid_q;
    ibus_err_d  = ibus_err_q;
    align_err_d = align_err_q;
`ifdef FETCH_SKID_EN
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_flush = 1'b0;
`endif
    if (branch_taken_in) begin
      // Redirect outranks stall and ack: anything presented or fetched is stale.
      valid_d    = 1'b0;
      ibus_err_d = 1'b0;
`ifdef FETCH_SKID_EN
      buf_flush = 1'b1;
`endif
      if (branch_target_in[1:0] != 2'b00) begin
        align_err_d = 1'b1;
        state_d     = S_ERR;
      end else begin
        align_err_d = 1'b0;
        pc_d        = branch_target_in;
        drop_addr_d = addr_raw;
        state_d     = (imem_req_out && !imem_ack_in) ? S_DROP : S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH, S_HOLD: begin
          if (consume) begin
            valid_d    = 1'b0;
            ibus_err_d = 1'b0;
            if (buf_vld) begin
              inst_d     = buf_inst;
              iaddr_d    = buf_pc;
              ibus_err_d = buf_err;
              valid_d    = 1'b1;
`ifdef FETCH_SKID_EN
              buf_pop = 1'b1;
`endif
            end
          end
          if (ack) begin
            pc_d = pc_next(pc_q);
            if (!out_busy) begin
              inst_d     = resp_inst;
              iaddr_d    = pc_q;
              ibus_err_d = imem_err_in;
              valid_d    = 1'b1;
            end
`ifdef FETCH_SKID_EN
            else begin
              buf_push = 1'b1;
            end
`endif
          end
          state_d = out_busy ? S_HOLD : S_FETCH;
        end
        S_DROP: begin
          if (ack) state_d = S_FETCH;
        end
        default: ;  // S_ERR waits for an aligned redirect
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      // A request still open when reset hit will be answered later; park in
      // S_DROP so that response is swallowed instead of taken as RESET_PC's word.
      state_q     <= ((state_q == S_DROP || (run_q && req_raw)) && !imem_ack_in) ? S_DROP : S_FETCH;
      drop_addr_q <= addr_raw;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      iaddr_q     <= '0;
      valid_q     <= 1'b0;
      ibus_err_q  <= 1'b0;
      align_err_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_addr_q <= drop_addr_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      iaddr_q     <= iaddr_d;
      valid_q     <= valid_d;
      ibus_err_q  <= ibus_err_d;
      align_err_q <= align_err_d;
      run_q       <= 1'b1;
    end
  end

  assign inst_out           = inst_q;
  assign pc_out             = iaddr_q;
  assign inst_valid_out     = valid_q;
  assign flag_ibus_err_out  = ibus_err_q;
  assign flag_align_err_out = align_err_q;

endmodule

// File: tb/tb_fetch_32i.sv
// Directed vector bench for fetch_32i: each record drives one cycle of inputs and
// lists the outputs expected in that same cycle (sampled 2 time units after the falling edge).
module tb_fetch_32i;

  localparam logic [31:0] NOP = 32'h1500_0000;
`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 1'b0;
  logic        imem_err_in = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid_out;
  logic        flag_ibus_err_out;
  logic        flag_align_err_out;

  fetch_32i dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .imem_req_out       (imem_req_out),
    .imem_addr_out      (imem_addr_out),
    .imem_ack_in        (imem_ack_in),
    .imem_err_in        (imem_err_in),
    .imem_data_in       (imem_data_in),
    .stall_in           (stall_in),
    .branch_taken_in    (branch_taken_in),
    .branch_target_in   (branch_target_in),
    .inst_out           (inst_out),
    .pc_out             (pc_out),
    .inst_valid_out     (inst_valid_out),
    .flag_ibus_err_out  (flag_ibus_err_out),
    .flag_align_err_out (flag_align_err_out)
  );

  always #5 clk_in = ~clk_in;

  // ins = {rst_n, ack, err, stall, branch}; exp = {req, valid, ibus_err, align_err}
  typedef struct {
    bit          chk;
    bit          full;   // compare inst/pc even when valid is expected low
    logic [4:0]  ins;
    logic [31:0] tgt;
    logic [31:0] data;
    logic [3:0]  exp;
    logic [31:0] eaddr;
    logic [31:0] einst;
    logic [31:0] epc;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  function automatic vec_t mk(input logic [4:0] ins, input logic [31:0] tgt, input logic [31:0] data,
                              input logic [3:0] exp, input logic [31:0] eaddr,
                              input logic [31:0] einst, input logic [31:0] epc);
    vec_t v;
    v.chk = 1'b1; v.ins = ins; v.tgt = tgt; v.data = data;
    v.exp = exp; v.eaddr = eaddr; v.einst = einst; v.epc = epc;
    v.full = exp[2];
    return v;
  endfunction

  task automatic step(input string nm, input vec_t v);
    bit ok;
    {reset_in, imem_ack_in, imem_err_in, stall_in, branch_taken_in} = v.ins;
    branch_target_in = v.tgt;
    imem_data_in     = v.data;
    #2;
    if (v.chk) begin
      ok = (imem_req_out === v.exp[3])
        && (!v.exp[3] || imem_addr_out === v.eaddr)
        && (inst_valid_out === v.exp[2])
        && (flag_ibus_err_out === v.exp[1])
        && (flag_align_err_out === v.exp[0])
        && (!v.full || (inst_out === v.einst && pc_out === v.epc));
      nvec++;
      if (!ok) begin
        nmis++;
        $display("FAIL %s: got req=%b addr=%h vld=%b inst=%h pc=%h ierr=%b aerr=%b; want req=%b addr=%h vld=%b inst=%h pc=%h ierr=%b aerr=%b",
                 nm, imem_req_out, imem_addr_out, inst_valid_out, inst_out, pc_out,
                 flag_ibus_err_out, flag_align_err_out,
                 v.exp[3], v.eaddr, v.exp[2], v.einst, v.epc, v.exp[1], v.exp[0]);
      end
    end
    @(negedge clk_in);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Reset: first cycle unchecked (registers not yet reset), second checks the reset state.
    v = mk(5'b00000, 0, 0, 4'b0000, 0, 0, 0); v.chk = 1'b0; tbl.push_back(v);
    v = mk(5'b00000, 0, 0, 4'b0000, 0, 0, 0); v.full = 1'b1; tbl.push_back(v);
    // Back-to-back fetch from RESET_PC.
    tbl.push_back(mk(5'b11000, 0, 32'hD000_0100, 4'b1000, 32'h100, 0, 0));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_0104, 4'b1100, 32'h104, 32'hD000_0100, 32'h100));
    // Stall 3 cycles with 0x104 presented, then release.
    tbl.push_back(mk(5'b10010, 0, 0, {SKID, 3'b100}, 32'h108, 32'hD000_0104, 32'h104));
    tbl.push_back(mk(5'b10010, 0, 0, {SKID, 3'b100}, 32'h108, 32'hD000_0104, 32'h104));
    tbl.push_back(mk(5'b10010, 0, 0, {SKID, 3'b100}, 32'h108, 32'hD000_0104, 32'h104));
    tbl.push_back(mk(5'b10000, 0, 0, {SKID, 3'b100}, 32'h108, 32'hD000_0104, 32'h104));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_0108, 4'b1000, 32'h108, 0, 0));
    // Redirect to 0x2000 while 0x10C is pending two cycles.
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1100, 32'h10C, 32'hD000_0108, 32'h108));
    tbl.push_back(mk(5'b10001, 32'h2000, 0, 4'b1000, 32'h10C, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1000, 32'h10C, 0, 0));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_010C, 4'b1000, 32'h10C, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1000, 32'h2000, 0, 0));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_2000, 4'b1000, 32'h2000, 0, 0));
    // Misaligned redirect 0x2002 (same cycle as an ack), acks ignored, then aligned 0x3000.
    tbl.push_back(mk(5'b11001, 32'h2002, 32'hD000_2004, 4'b1100, 32'h2004, 32'hD000_2000, 32'h2000));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_2004, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(5'b10001, 32'h3000, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1000, 32'h3000, 0, 0));
    // Redirect to 0x200 in the same cycle as the 0x3000 ack: data dropped.
    tbl.push_back(mk(5'b11001, 32'h200, 32'hD000_3000, 4'b1000, 32'h3000, 0, 0));
    // Bus error at 0x200 becomes l.nop with the error flag.
    tbl.push_back(mk(5'b11100, 0, 32'hDEAD_BEEF, 4'b1000, 32'h200, 0, 0));
    tbl.push_back(mk(5'b11000, 0, 32'hD000_0204, 4'b1110, 32'h204, NOP, 32'h200));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1100, 32'h208, 32'hD000_0204, 32'h204));
    tbl.push_back(mk(5'b10000, 0, 0, 4'b1000, 32'h208, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // PC wrap at the top of the address space.
    step("wrap_redirect", mk(5'b11001, 32'hFFFF_FFFC, 32'hD000_0208, 4'b1000, 32'h208, 0, 0));
    step("wrap_top",      mk(5'b11000, 0, 32'hCAFE_FFFC, 4'b1000, 32'hFFFF_FFFC, 0, 0));
    step("wrap_zero",     mk(5'b10000, 0, 0, 4'b1100, 32'h0000_0000, 32'hCAFE_FFFC, 32'hFFFF_FFFC));

    // Reset while the request at 0x0 is open: its late response is discarded.
    step("rst_req_low", mk(5'b00000, 0, 0, 4'b0000, 0, 0, 0));
    v = mk(5'b00000, 0, 0, 4'b0000, 0, 0, 0); v.full = 1'b1;
    step("rst_state", v);
    step("rst_drop_req", mk(5'b10000, 0, 0, 4'b1000, 32'h0, 0, 0));
    step("rst_drop_ack", mk(5'b11000, 0, 32'hBAD0_0000, 4'b1000, 32'h0, 0, 0));
    step("rst_first",    mk(5'b11000, 0, 32'hD000_0100, 4'b1000, 32'h100, 0, 0));
    step("rst_present",  mk(5'b10000, 0, 0, 4'b1100, 32'h104, 32'hD000_0100, 32'h100));

`ifdef FETCH_SKID_EN
    // One extra request while stalled, presented the cycle after release.
    step("skid_ack104",  mk(5'b11000, 0, 32'hD000_0104, 4'b1000, 32'h104, 0, 0));
    step("skid_req108",  mk(5'b10010, 0, 0, 4'b1100, 32'h108, 32'hD000_0104, 32'h104));
    step("skid_ack108",  mk(5'b11010, 0, 32'hD000_0108, 4'b1100, 32'h108, 32'hD000_0104, 32'h104));
    step("skid_full",    mk(5'b10010, 0, 0, 4'b0100, 0, 32'hD000_0104, 32'h104));
    step("skid_release", mk(5'b10000, 0, 0, 4'b0100, 0, 32'hD000_0104, 32'h104));
    step("skid_present", mk(5'b10000, 0, 0, 4'b1100, 32'h10C, 32'hD000_0108, 32'h108));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
